// File: rtl/keypad_scanner_pkg.sv
// Shared keypad definitions: FSM states, row drive patterns, scan classes.
// Reused by keypad_scanner, key_encoder and the future top level.
package keypad_scanner_pkg;

    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_PRESSED = 1'b1;

    typedef enum logic {
        S_IDLE    = ST_IDLE,
        S_PRESSED = ST_PRESSED
    } state_t;

    typedef enum logic [1:0] {
        SCAN_NONE   = 2'd0,
        SCAN_SINGLE = 2'd1,
        SCAN_MULTI  = 2'd2
    } scan_t;

    localparam logic [3:0] COL_NONE   = 4'hF;
    localparam logic [3:0] ROW_DRIVE0 = 4'b1110;
    localparam logic [3:0] ROW_DRIVE1 = 4'b1101;
    localparam logic [3:0] ROW_DRIVE2 = 4'b1011;
    localparam logic [3:0] ROW_DRIVE3 = 4'b0111;

    function automatic logic [3:0] row_drive(input logic [1:0] r);
        logic [3:0] d;
        d = ROW_DRIVE0;
        unique case (r)
            2'd0: d = ROW_DRIVE0;
            2'd1: d = ROW_DRIVE1;
            2'd2: d = ROW_DRIVE2;
            2'd3: d = ROW_DRIVE3;
        endcase
        return d;
    endfunction

    function automatic logic [2:0] low_count(input logic [3:0] c);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, ~c[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for asynchronous inputs.
// Resets to all-ones so idle pulled-up lines read inactive.
module keypad_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with full-scan debounce and ghost rejection.
// Outputs a row index plus active-low one-hot column for key_encoder.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_TICKS     = 50000,
    parameter int DEBOUNCE_SCANS = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] kp_col_n,
    output logic [3:0] kp_row_n,
    output logic [1:0] row,
    output logic [3:0] col,
    output logic       key_valid,
    output logic       key_down
);

    localparam int DW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_TICKS - 1);
    localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

    logic [3:0]    col_sync;
    logic [DW-1:0] dwell;
    logic [1:0]    scan_row;
    logic          sample_en;
    logic          eval_pending;
    logic [2:0]    lows;

    logic [2:0] ones_rows;
    logic       multi_seen;
    logic [1:0] cand_row;
    logic [3:0] cand_col;

    state_t     state;
    scan_t      res;
    logic [3:0] stable_cnt;
    logic [3:0] release_cnt;
    logic [3:0] stable_next;
    logic [3:0] release_next;
    logic [1:0] prev_row;
    logic [3:0] prev_col;

    keypad_sync #(.WIDTH(4)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (kp_col_n),
        .q     (col_sync)
    );

    assign sample_en = (dwell == DWELL_LAST);
    assign lows      = low_count(col_sync);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell        <= '0;
            scan_row     <= 2'd0;
            kp_row_n     <= ROW_DRIVE0;
            eval_pending <= 1'b0;
        end else begin
            eval_pending <= sample_en && (scan_row == 2'd3);
            if (sample_en) begin
                dwell    <= '0;
                scan_row <= scan_row + 2'd1;
                kp_row_n <= row_drive(scan_row + 2'd1);
            end else begin
                dwell <= dwell + 1'b1;
            end
        end
    end

    // Accumulators are cleared on the evaluation edge; the next
    // row-0 sample is always at least three cycles later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_rows  <= 3'd0;
            multi_seen <= 1'b0;
            cand_row   <= 2'd0;
            cand_col   <= COL_NONE;
        end else if (eval_pending) begin
            ones_rows  <= 3'd0;
            multi_seen <= 1'b0;
        end else if (sample_en) begin
            if (lows == 3'd1) begin
                ones_rows <= ones_rows + 3'd1;
                cand_row  <= scan_row;
                cand_col  <= col_sync;
            end else if (lows > 3'd1) begin
                multi_seen <= 1'b1;
            end
        end
    end

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c >= DEB) ? DEB : c + 4'd1;
    endfunction

    always_comb begin
        res          = SCAN_MULTI;
        stable_next  = 4'd0;
        release_next = 4'd0;
        unique case (1'b1)
            (ones_rows == 3'd0 && !multi_seen): res = SCAN_NONE;
            (ones_rows == 3'd1 && !multi_seen): res = SCAN_SINGLE;
            default: res = SCAN_MULTI;
        endcase
        if (res == SCAN_SINGLE) begin
            if (cand_row == prev_row && cand_col == prev_col)
                stable_next = sat_inc(stable_cnt);
            else
                stable_next = 4'd1;
        end
        if (res == SCAN_NONE)
            release_next = sat_inc(release_cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            stable_cnt  <= 4'd0;
            release_cnt <= 4'd0;
            prev_row    <= 2'd0;
            prev_col    <= COL_NONE;
            row         <= 2'd0;
            col         <= COL_NONE;
            key_valid   <= 1'b0;
            key_down    <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (eval_pending) begin
                unique case (state)
                    S_IDLE: begin
                        stable_cnt <= stable_next;
                        if (res == SCAN_SINGLE) begin
                            prev_row <= cand_row;
                            prev_col <= cand_col;
                        end
                        if (stable_next == DEB) begin
                            state       <= S_PRESSED;
                            row         <= cand_row;
                            col         <= cand_col;
                            key_valid   <= 1'b1;
                            key_down    <= 1'b1;
                            release_cnt <= 4'd0;
                        end
                    end
                    S_PRESSED: begin
                        release_cnt <= release_next;
                        if (release_next == DEB) begin
                            state      <= S_IDLE;
                            key_down   <= 1'b0;
                            col        <= COL_NONE;
                            stable_cnt <= 4'd0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboarded bench for keypad_scanner: directed scenarios then random key runs.
// Reference model works on whole-scan results derived from the pressed-key set.
module tb_keypad_scanner;

    localparam int ST   = 4;
    localparam int DB   = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] kp_col_n;
    logic [3:0] kp_row_n;
    logic [1:0] row;
    logic [3:0] col;
    logic       key_valid;
    logic       key_down;
    logic [15:0] keys = '0;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int m_hist[$];
    bit m_down = 1'b0;
    int m_key = 0;
    int m_row = 0;

    keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .kp_col_n  (kp_col_n),
        .kp_row_n  (kp_row_n),
        .row       (row),
        .col       (col),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    always #5 clk = ~clk;

    // Ideal matrix: a column reads low if a pressed key in a driven row sits on it.
    always_comb begin
        kp_col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!kp_row_n[r] && keys[r*4+c]) kp_col_n[c] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] col_of(input int k);
        logic [3:0] c;
        c = 4'hF;
        c[k % 4] = 1'b0;
        return c;
    endfunction

    // -1 = no key, -2 = several keys, otherwise the key index row*4+col
    function automatic int classify(input logic [15:0] m);
        int r;
        r = -2;
        if ($countones(m) == 0) r = -1;
        else if ($countones(m) == 1)
            for (int i = 0; i < 16; i++) if (m[i]) r = i;
        return r;
    endfunction

    task automatic model_step(input int res);
        int run;
        run = 0;
        m_hist.push_back(res);
        if (!m_down) begin
            if (res >= 0)
                for (int i = m_hist.size() - 1; i >= 0 && m_hist[i] == res; i--) run++;
            if (run >= DB) begin
                m_down = 1'b1;
                m_key = res;
                m_row = res / 4;
                exp_q.push_back(res);
                m_hist.delete();
            end
        end else begin
            for (int i = m_hist.size() - 1; i >= 0 && m_hist[i] == -1; i--) run++;
            if (run >= DB) begin
                m_down = 1'b0;
                m_hist.delete();
            end
        end
    endtask

    // One full 16-cycle scan with a fixed key set, entered on a scan boundary.
    task automatic run_scan(input logic [15:0] m);
        keys = m;
        repeat (2) @(negedge clk);
        check("key_down", key_down, m_down);
        check("col_level", col, m_down ? col_of(m_key) : 4'hF);
        check("row_level", row, m_row);
        repeat (6) @(negedge clk);
        check("kp_row_n_row2", kp_row_n, 4'b1011);
        model_step(classify(m));
        repeat (8) @(negedge clk);
    endtask

    task automatic run_n(input logic [15:0] m, input int n);
        for (int i = 0; i < n; i++) run_scan(m);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && key_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse row=%0d col=%h required no pulse", row, col);
            end else begin
                int k;
                k = exp_q.pop_front();
                check("pulse_row", row, k / 4);
                check("pulse_col", col, col_of(k));
            end
        end
    end

    localparam logic [15:0] K1 = 16'h0001;
    localparam logic [15:0] K5 = 16'h0020;
    localparam logic [15:0] K6 = 16'h0040;
    localparam logic [15:0] K7 = 16'h0100;
    localparam logic [15:0] K8 = 16'h0200;
    localparam logic [15:0] K9 = 16'h0400;
    localparam logic [15:0] KH = 16'h4000;
    localparam logic [15:0] KD = 16'h8000;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_kp_row_n", kp_row_n, 4'b1110);
        check("rst_row", row, 0);
        check("rst_col", col, 4'hF);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_down", key_down, 0);
        rst_n = 1'b1;

        run_n(K5, 6);
        run_n(0, 3);
        run_n(K5, 4);
        run_n(0, 2);
        run_n(K5, 3);
        run_n(0, 3);

        for (int i = 0; i < 6; i++) run_scan((i % 2 == 0) ? K9 : 16'h0);
        run_n(K9, 4);
        run_n(0, 3);

        run_n(K1 | K6, 4);
        run_n(K7 | K8, 4);
        run_n(0, 1);

        run_n(KD, 3);
        run_n(KH, 4);
        run_n(0, 3);
        run_n(KH, 3);
        run_n(0, 3);

        run_n(K5, 4);
        keys = K5;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_kp_row_n", kp_row_n, 4'b1110);
        check("arst_row", row, 0);
        check("arst_col", col, 4'hF);
        check("arst_key_valid", key_valid, 0);
        check("arst_key_down", key_down, 0);
        check("arst_pending", exp_q.size(), 0);
        m_down = 1'b0;
        m_row = 0;
        m_hist.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_n(K5, 5);
        run_n(0, 3);

        for (int p = 0; p < 40; p++) begin
            int sel;
            logic [15:0] m;
            sel = $urandom_range(0, 99);
            m = '0;
            if (sel < 40) m = '0;
            else if (sel < 85) m[$urandom_range(0, 15)] = 1'b1;
            else begin
                m[$urandom_range(0, 15)] = 1'b1;
                m[$urandom_range(0, 15)] = 1'b1;
                if ($countones(m) < 2) m = m | 16'h0081;
            end
            run_n(m, $urandom_range(1, 5));
        end
        run_n(0, 4);
        repeat (4) @(negedge clk);
        check("missing_pulses", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
